// File: rtl/sd_init_sequencer.sv
// SD-card SPI-mode initialisation sequencer: SPI reset, dummy clocks, CMD0/CMD8/CMD55+ACMD41/CMD16,
// each frame issued, awaited with a timeout and its R1/R7 response decoded.
module sd_init_sequencer #(
    parameter int         RST_CYCLES   = 16,
    parameter int         DUMMY_FRAMES = 2,
    parameter int         CMD0_RETRY   = 8,
    parameter int         ACMD41_RETRY = 1000,
    parameter int         TIMEOUT      = 65535,
    parameter logic [1:0] SLOW_DIV     = 2'b11,
    parameter logic [1:0] FAST_DIV     = 2'b00
) (
    input  logic        control_clk_i,
    input  logic        control_rst_i,
    input  logic        init_start_i,
    input  logic        spi_done_i,
    input  logic [47:0] spi_data_i,
    output logic        spi_rst_o,
    output logic        spi_start_o,
    output logic [47:0] instruction_sd_o,
    output logic [1:0]  clock_divider_o,
    output logic        init_busy_o,
    output logic        init_done_o,
    output logic        init_error_o,
    output logic [3:0]  error_code_o
);

    localparam logic [3:0] S_IDLE = 4'd0, S_SPI_RST = 4'd1, S_DUMMY = 4'd2, S_CMD0 = 4'd3,
                           S_CMD8 = 4'd4, S_CMD55 = 4'd5, S_ACMD41 = 4'd6, S_CMD16 = 4'd7,
                           S_DONE = 4'd8, S_ERROR = 4'd9;
    localparam logic [1:0] P_ISSUE = 2'd0, P_WAIT = 2'd1, P_CHECK = 2'd2;

    localparam int RW  = $clog2(RST_CYCLES + 1);
    localparam int DW  = $clog2(DUMMY_FRAMES + 1);
    localparam int C0W = $clog2(CMD0_RETRY + 1);
    localparam int AW  = $clog2(ACMD41_RETRY + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [RW-1:0]  RST_LAST   = RW'(RST_CYCLES - 1);
    localparam logic [DW-1:0]  DUMMY_LAST = DW'(DUMMY_FRAMES - 1);
    localparam logic [C0W-1:0] C0_LAST    = C0W'(CMD0_RETRY - 1);
    localparam logic [AW-1:0]  A_LAST     = AW'(ACMD41_RETRY - 1);
    localparam logic [TW-1:0]  T_LAST     = TW'(TIMEOUT - 1);

    logic [3:0]     state;
    logic [1:0]     phase;
    logic [RW-1:0]  rst_cnt;
    logic [DW-1:0]  dummy_cnt;
    logic [C0W-1:0] c0_cnt;
    logic [AW-1:0]  a_cnt;
    logic [TW-1:0]  timer;
    logic           done_q;
    logic [7:0]     r1_q;
    logic [11:0]    chk_q;
    logic           done_rise;
    logic           unused_rx;

    assign done_rise = spi_done_i & ~done_q;
    assign unused_rx = ^{spi_data_i[39:20], spi_data_i[7:0]};

    function automatic logic [47:0] frame_of(input logic [3:0] st);
        case (st)
            S_CMD0:   return 48'h40_00000000_95;
            S_CMD8:   return 48'h48_000001AA_87;
            S_CMD55:  return 48'h77_00000000_01;
            S_ACMD41: return 48'h69_40000000_01;
            S_CMD16:  return 48'h50_00000200_01;
            default:  return 48'hFFFF_FFFF_FFFF;
        endcase
    endfunction

    task automatic go_error(input logic [3:0] code);
        state           <= S_ERROR;
        init_busy_o     <= 1'b0;
        init_error_o    <= 1'b1;
        error_code_o    <= code;
        clock_divider_o <= SLOW_DIV;
    endtask

    always_ff @(posedge control_clk_i) begin
        if (control_rst_i) begin
            state            <= S_IDLE;
            phase            <= P_ISSUE;
            rst_cnt          <= '0;
            dummy_cnt        <= '0;
            c0_cnt           <= '0;
            a_cnt            <= '0;
            timer            <= '0;
            done_q           <= 1'b0;
            r1_q             <= '0;
            chk_q            <= '0;
            spi_rst_o        <= 1'b1;
            spi_start_o      <= 1'b0;
            instruction_sd_o <= 48'hFFFF_FFFF_FFFF;
            clock_divider_o  <= SLOW_DIV;
            init_busy_o      <= 1'b0;
            init_done_o      <= 1'b0;
            init_error_o     <= 1'b0;
            error_code_o     <= '0;
        end else begin
            done_q      <= spi_done_i;
            spi_start_o <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (init_start_i) begin
                        state           <= S_SPI_RST;
                        phase           <= P_ISSUE;
                        init_busy_o     <= 1'b1;
                        init_done_o     <= 1'b0;
                        init_error_o    <= 1'b0;
                        error_code_o    <= '0;
                        clock_divider_o <= SLOW_DIV;
                        spi_rst_o       <= 1'b1;
                        rst_cnt         <= '0;
                        dummy_cnt       <= '0;
                        c0_cnt          <= '0;
                        a_cnt           <= '0;
                    end
                end
                S_SPI_RST: begin
                    if (rst_cnt == RST_LAST) begin
                        spi_rst_o <= 1'b0;
                        state     <= S_DUMMY;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                S_DUMMY, S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD16: begin
                    case (phase)
                        P_ISSUE: begin
                            instruction_sd_o <= frame_of(state);
                            spi_start_o      <= 1'b1;
                            timer            <= '0;
                            phase            <= P_WAIT;
                        end
                        P_WAIT: begin
                            // only a fresh edge counts; a level left high from the last frame is ignored
                            if (done_rise) begin
                                r1_q  <= spi_data_i[47:40];
                                chk_q <= spi_data_i[19:8];
                                phase <= P_CHECK;
                            end else if (timer == T_LAST) begin
                                go_error(4'hF);
                            end else begin
                                timer <= timer + 1'b1;
                            end
                        end
                        default: begin
                            phase <= P_ISSUE;
                            case (state)
                                S_DUMMY:
                                    if (dummy_cnt == DUMMY_LAST) state <= S_CMD0;
                                    else dummy_cnt <= dummy_cnt + 1'b1;
                                S_CMD0:
                                    if (r1_q == 8'h01) state <= S_CMD8;
                                    else if (c0_cnt == C0_LAST) go_error(4'h1);
                                    else c0_cnt <= c0_cnt + 1'b1;
                                S_CMD8:
                                    if (r1_q == 8'h01 && chk_q == 12'h1AA) state <= S_CMD55;
                                    else go_error(4'h2);
                                S_CMD55:
                                    if (r1_q == 8'h00 || r1_q == 8'h01) state <= S_ACMD41;
                                    else go_error(4'h5);
                                S_ACMD41:
                                    if (r1_q == 8'h00) state <= S_CMD16;
                                    else if (r1_q == 8'h01 && a_cnt != A_LAST) begin
                                        a_cnt <= a_cnt + 1'b1;
                                        state <= S_CMD55;
                                    end else go_error(4'h3);
                                default:
                                    if (r1_q == 8'h00) begin
                                        state            <= S_DONE;
                                        init_busy_o      <= 1'b0;
                                        init_done_o      <= 1'b1;
                                        clock_divider_o  <= FAST_DIV;
                                        instruction_sd_o <= 48'hFFFF_FFFF_FFFF;
                                    end else go_error(4'h4);
                            endcase
                        end
                    endcase
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
